// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped input port: bus width, register
// offsets and address decode helpers.
package mmio_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_COUNT = 4;

  localparam logic [1:0] OFF_PIN      = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_IE       = 2'd2;
  localparam logic [1:0] OFF_EDGE_SEL = 2'd3;

  // Widened to 17 bits so a base near 16'hFFFF cannot wrap into the window.
  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                         input logic [DATA_W-1:0] base);
    logic [DATA_W:0] a;
    logic [DATA_W:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < b + (DATA_W+1)'(REG_COUNT));
  endfunction

  function automatic logic [1:0] addr_offset(input logic [DATA_W-1:0] addr,
                                             input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] diff;
    diff = addr - base;
    return diff[1:0];
  endfunction

endpackage

// File: rtl/input_sync_filter.sv
// One input pin: multi-flop synchroniser followed by a level register, with an
// optional debounce counter when MMIO_INPUT_DEBOUNCE_EN is defined.
module input_sync_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  input  logic track_i,
  output logic level_o,
  output logic level_d_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level_q, level_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      level_q <= level_d;
    end
  end

`ifdef MMIO_INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // While tracking (warm-up) the level follows the synchroniser directly.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (track_i) begin
      level_d = synced;
    end else if (synced != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = synced;
      else                                    cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_track;
  assign unused_track = track_i;
  assign level_d      = synced;
`endif

  assign level_o   = level_q;
  assign level_d_o = level_d;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped input port: synchronised pins, edge-detect sticky STATUS, IE
// and EDGE_SEL registers, registered reads and irq. Debounce: MMIO_INPUT_DEBOUNCE_EN.
module mmio_input_port
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = 16'h0002,
  parameter int          WIDTH           = 8,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic              we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              hit,
  input  logic [WIDTH-1:0]  pins,
  output logic [WIDTH-1:0]  irq
);

  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int WW       = $clog2(WARM_MAX + 1);

  logic [WW-1:0]     warm_q, warm_d;
  logic              warm_done;
  logic [WIDTH-1:0]  filt, filt_next;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  status_q, status_d;
  logic [WIDTH-1:0]  ie_q, ie_d;
  logic [WIDTH-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0]  irq_q, irq_d;
  logic [WIDTH-1:0]  evt, w1c;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d;
  logic              in_range, wr_en;
  logic [1:0]        off;
  logic              unused_wdata;

  assign unused_wdata = ^wdata;
  assign warm_done    = (warm_q == WW'(WARM_MAX));

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    input_sync_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_i    (pins[g]),
      .track_i  (~warm_done),
      .level_o  (filt[g]),
      .level_d_o(filt_next[g])
    );
  end

  assign in_range = addr_in_range(addr, BASE_ADDR);
  assign off      = addr_offset(addr, BASE_ADDR);
  assign wr_en    = we & in_range;

  // NOTE: every variable gets a default before the branches, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w1c     = '0;
    ie_d    = ie_q;
    sel_d   = sel_q;
    rdata_d = '0;
    if (wr_en) begin
      case (off)
        OFF_STATUS:   w1c   = wdata[WIDTH-1:0];
        OFF_IE:       ie_d  = wdata[WIDTH-1:0];
        OFF_EDGE_SEL: sel_d = wdata[WIDTH-1:0];
        default:      ;
      endcase
    end
    // Read mux sees pre-write register contents.
    if (in_range) begin
      case (off)
        OFF_PIN:    rdata_d[WIDTH-1:0] = filt;
        OFF_STATUS: rdata_d[WIDTH-1:0] = status_q;
        OFF_IE:     rdata_d[WIDTH-1:0] = ie_q;
        default:    rdata_d[WIDTH-1:0] = sel_q;
      endcase
    end
  end

  // During warm-up prev is preloaded with the level the filter is about to
  // take, so a pin held high through reset never looks like a fresh edge.
  assign evt      = warm_done ? ((filt & ~prev_q & ~sel_q) | (~filt & prev_q & sel_q)) : '0;
  assign prev_d   = warm_done ? filt : filt_next;
  assign warm_d   = warm_done ? warm_q : warm_q + WW'(1);
  assign status_d = (status_q & ~w1c) | evt;
  assign irq_d    = status_d & ie_d;
  assign hit_d    = in_range;

  // NOTE: no memories here, so every register is cleared by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q   <= '0;
      prev_q   <= '0;
      status_q <= '0;
      ie_q     <= '0;
      sel_q    <= '0;
      irq_q    <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
    end else begin
      warm_q   <= warm_d;
      prev_q   <= prev_d;
      status_q <= status_d;
      ie_q     <= ie_d;
      sel_q    <= sel_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
    end
  end

  assign rdata = rdata_q;
  assign hit   = hit_q;
  assign irq   = irq_q;

endmodule
